// File: rtl/linebuf_pkg.sv
// Shared definitions for the line-buffer sequencer: state encoding,
// a constant-friendly clog2 and the line-index width rule.
package linebuf_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        FILL  = S_FILL,
        RUN   = S_RUN,
        DRAIN = S_DRAIN
    } lb_state_t;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Line index width is clog2(K), kept at least one bit wide.
    function automatic int unsigned lidx_w(input int unsigned k);
        return (clog2(k) < 1) ? 1 : clog2(k);
    endfunction

endpackage

// File: rtl/lb_ring_ptr.sv
// Modulo-N ring pointer with synchronous clear and increment.
// The wrap uses an explicit compare so N need not be a power of two.
module lb_ring_ptr
    import linebuf_pkg::*;
#(
    parameter int unsigned N = 3,
    parameter int unsigned W = lidx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    // Pointer register: clear wins over increment, N-1 wraps to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/linebuf_ctrl.sv
// Sequencer for a K-line BRAM line buffer. Pixel data bypasses this block;
// it only generates write enables, addresses, the rotation pointer and the
// window-valid handshake toward the window/MAC stage.
// Optional feature macro: LINEBUF_CTRL_STALL_CNT_EN adds stall_cnt.
//
// Handshakes: a beat moves on s_valid & s_ready, a column moves on
// win_valid & m_ready; once raised, win_valid stays high until consumed and
// no new BRAM read is issued while it is held.
module linebuf_ctrl
    import linebuf_pkg::*;
#(
    parameter int unsigned K      = 3,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned ROW_W  = 12,
    parameter int unsigned LIDX_W = lidx_w(K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_width,
    input  logic [ROW_W-1:0]  cfg_height,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [K-1:0]      wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LIDX_W-1:0] rd_line_base,
    output logic              win_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
`ifdef LINEBUF_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    lb_state_t         cur_state;
    lb_state_t         nxt_state;
    logic [ADDR_W-1:0] width_r;
    logic [ROW_W-1:0]  height_r;
    logic [ADDR_W-1:0] col;
    logic [ROW_W-1:0]  row;
    logic [LIDX_W-1:0] wr_ptr;
    logic              start_acc;
    logic              accept;
    logic              run_acc;
    logic              col_last;
    logic              row_last;
    logic              ptr_inc;
    logic              base_inc;

    assign start_acc = start & (cur_state == IDLE);
    assign accept    = s_valid & s_ready;
    assign run_acc   = accept & (cur_state == RUN);
    assign col_last  = (col == width_r - 1'b1);
    assign row_last  = (row == height_r - 1'b1);
    // Pointers hold on the final beat so rd_line_base still names the last
    // row's window while it drains.
    assign ptr_inc   = accept & col_last & ~row_last;
    assign base_inc  = run_acc & col_last & ~row_last;

    assign busy      = (cur_state != IDLE);
    assign state     = cur_state;
    assign wr_en     = accept ? (K'(1) << wr_ptr) : '0;
    assign wr_addr   = col;
    assign rd_addr   = col;
    assign rd_en     = run_acc;

    // Frame configuration, sampled only when a start is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_r  <= ADDR_W'(1);
            height_r <= ROW_W'(1);
        end else if (start_acc) begin
            width_r  <= (cfg_width == '0) ? ADDR_W'(1) : cfg_width;
            height_r <= (cfg_height == '0) ? ROW_W'(1) : cfg_height;
        end
    end

    // Column/row position of the next beat within the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (start_acc) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Window valid: raised one cycle after a RUN read, held until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
        end else if (run_acc) begin
            win_valid <= 1'b1;
        end else if (m_ready) begin
            win_valid <= 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur_state <= IDLE;
        else     cur_state <= nxt_state;
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        s_ready = 1'b0;
        done    = 1'b0;
        case (cur_state)
            FILL:    s_ready = 1'b1;
            RUN:     s_ready = ~win_valid | m_ready;
            DRAIN:   done    = ~win_valid | m_ready;
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE: begin
                if (start) nxt_state = FILL;
            end
            FILL: begin
                if (accept && col_last) begin
                    if (row_last)                  nxt_state = DRAIN;
                    else if (row == ROW_W'(K - 2)) nxt_state = RUN;
                end
            end
            RUN: begin
                if (accept && col_last && row_last) nxt_state = DRAIN;
            end
            DRAIN: begin
                if (~win_valid | m_ready) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    lb_ring_ptr #(.N(K), .W(LIDX_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (start_acc),
        .inc   (ptr_inc),
        .ptr   (wr_ptr)
    );

    lb_ring_ptr #(.N(K), .W(LIDX_W)) u_rd_base (
        .clk   (clk),
        .rst   (rst),
        .clear (start_acc),
        .inc   (base_inc),
        .ptr   (rd_line_base)
    );

`ifdef LINEBUF_CTRL_STALL_CNT_EN
    // Saturating count of RUN cycles where a beat is offered but refused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if ((cur_state == RUN) && s_valid && !s_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Self-checking bench for linebuf_ctrl. The reference model tracks a frame as
// "beats accepted so far" and derives phase, line, column and expected window
// columns from that count with plain arithmetic.
module tb_linebuf_ctrl;

    localparam int K      = 3;
    localparam int ADDR_W = 8;
    localparam int ROW_W  = 12;
    localparam int LIDX_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] cfg_width;
    logic [ROW_W-1:0]  cfg_height;
    logic              s_valid;
    logic              s_ready;
    logic [K-1:0]      wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [LIDX_W-1:0] rd_line_base;
    logic              win_valid;
    logic              m_ready;
    logic              busy;
    logic              done;
    logic [1:0]        state;
`ifdef LINEBUF_CTRL_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: frame phase is a function of beats accepted.
    int m_busy, m_acc, m_w, m_h, m_wv, m_stall, m_last_col;
    int win_cnt, done_cnt;
    logic [31:0] exp_q[$];

    linebuf_ctrl #(.K(K), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .LIDX_W(LIDX_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_line_base (rd_line_base),
        .win_valid    (win_valid),
        .m_ready      (m_ready),
        .busy         (busy),
        .done         (done),
        .state        (state)
`ifdef LINEBUF_CTRL_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_phase();
        if (m_busy == 0)                return 0;
        if (m_acc == m_w * m_h)         return 3;
        if (m_acc >= (K - 1) * m_w)     return 2;
        return 1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_w = 1; m_h = 1;
        m_wv = 0; m_stall = 0; m_last_col = 0;
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},     32'(state), 0);
        check({tag, "_s_ready"},   32'(s_ready), 0);
        check({tag, "_wr_en"},     32'(wr_en), 0);
        check({tag, "_wr_addr"},   32'(wr_addr), 0);
        check({tag, "_rd_en"},     32'(rd_en), 0);
        check({tag, "_rd_addr"},   32'(rd_addr), 0);
        check({tag, "_base"},      32'(rd_line_base), 0);
        check({tag, "_win_valid"}, 32'(win_valid), 0);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_done"},      32'(done), 0);
`ifdef LINEBUF_CTRL_STALL_CNT_EN
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
`endif
    endtask

    // Asynchronous reset asserted between clock edges; leaves at a negedge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst");
        model_reset();
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: drive at a negedge, compare 1ns later, advance the model.
    task automatic step(input int st, input int sv, input int mr, input int cw, input int ch);
        int ph, row, col, e_ready, e_acc, e_done, e_wr_en;
        start      = (st != 0);
        s_valid    = (sv != 0);
        m_ready    = (mr != 0);
        cfg_width  = ADDR_W'(cw);
        cfg_height = ROW_W'(ch);
        #1;
        ph      = exp_phase();
        row     = m_acc / m_w;
        col     = m_acc % m_w;
        e_ready = (ph == 1) ? 1 : ((ph == 2) ? ((m_wv == 0 || mr != 0) ? 1 : 0) : 0);
        e_acc   = (sv != 0 && e_ready != 0) ? 1 : 0;
        e_done  = (ph == 3 && (m_wv == 0 || mr != 0)) ? 1 : 0;
        e_wr_en = (e_acc != 0) ? (1 << (row % K)) : 0;

        check("state",     32'(state), 32'(ph));
        check("s_ready",   32'(s_ready), 32'(e_ready));
        check("win_valid", 32'(win_valid), 32'(m_wv));
        check("busy",      32'(busy), 32'(m_busy));
        check("done",      32'(done), 32'(e_done));
        check("wr_en",     32'(wr_en), 32'(e_wr_en));
        check("wr_addr",   32'(wr_addr), 32'(col));
        check("rd_addr",   32'(rd_addr), 32'(col));
        check("rd_en",     32'(rd_en), (e_acc != 0 && ph == 2) ? 1 : 0);
        if (e_acc != 0)
            check("rd_line_base", 32'(rd_line_base), (ph == 2) ? 32'(((row % K) + 1) % K) : 0);
`ifdef LINEBUF_CTRL_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif

        // Scoreboard: each consumed column must be the next expected one.
        if (win_valid && mr != 0) begin
            win_cnt++;
            if (exp_q.size() == 0) check("window_extra", 1, 0);
            else                   check("window_col", 32'(m_last_col), exp_q.pop_front());
        end
        if (done) done_cnt++;

        if (m_busy == 0) begin
            if (st != 0) begin
                m_busy = 1; m_acc = 0; m_stall = 0; m_wv = 0;
                m_w = (cw % 256 == 0) ? 1 : cw % 256;
                m_h = (ch % 4096 == 0) ? 1 : ch % 4096;
                exp_q.delete();
                for (int r = K - 1; r < m_h; r++)
                    for (int c = 0; c < m_w; c++) exp_q.push_back(32'(c));
            end
        end else begin
            if (ph == 2 && sv != 0 && e_ready == 0 && m_stall < 65535) m_stall++;
            if (e_acc != 0 && ph == 2) begin
                m_wv = 1;
                m_last_col = col;
            end else if (mr != 0) begin
                m_wv = 0;
            end
            if (e_acc != 0) m_acc++;
            if (e_done != 0) m_busy = 0;
        end
        @(negedge clk);
    endtask

    // Run one frame; mid-frame starts carry random cfg and must be ignored.
    task automatic run_frame(input int w, input int h, input int sv_pct, input int mr_pct,
                             input int stall_at, input int stall_len, input int abort_at);
        int n, sv, mr, we, exp_win;
        win_cnt = 0; done_cnt = 0;
        we = (w == 0) ? 1 : w;
        step(1, 1, 1, w, h);
        n = 1;
        while (m_busy != 0 && n < 3000) begin
            if (n == abort_at) begin
                do_reset();
                return;
            end
            sv = ($urandom_range(0, 99) < sv_pct) ? 1 : 0;
            mr = ($urandom_range(0, 99) < mr_pct) ? 1 : 0;
            if (n >= stall_at && n < stall_at + stall_len) mr = 0;
            step(($urandom_range(0, 3) == 0) ? 1 : 0, sv, mr,
                 $urandom_range(1, 255), $urandom_range(1, 4095));
            n++;
        end
        check("frame_timeout", 32'(m_busy), 0);
        exp_win = (h >= K) ? we * (h - K + 1) : 0;
        check("windows", 32'(win_cnt), 32'(exp_win));
        check("done_pulses", 32'(done_cnt), 1);
        check("exp_q_left", 32'(exp_q.size()), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        cfg_width = '0; cfg_height = '0;
        model_reset();
        #1;
        check_all_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_frame(4, 5, 100, 100, -1, 0, -1);   // basic frame
        run_frame(4, 5, 100, 100, 12, 5, -1);   // downstream backpressure
        run_frame(2, 7, 100, 100, -1, 0, -1);   // ring wrap
        run_frame(4, 2, 100, 100, -1, 0, -1);   // short frame, no windows
        run_frame(4, 5, 100, 100, -1, 0, 12);   // reset mid-RUN
        run_frame(4, 5, 100, 100, -1, 0, -1);   // clean frame after reset
        run_frame(1, 4, 100, 100, 4, 3, -1);    // single column
`ifdef LINEBUF_CTRL_STALL_CNT_EN
        check("stall_cnt_w1", 32'(stall_cnt), 3);
`endif
        run_frame(0, 3, 100, 100, -1, 0, -1);   // width 0 behaves as 1
        for (int i = 0; i < 20; i++)
            run_frame($urandom_range(1, 6), $urandom_range(1, 8),
                      $urandom_range(40, 100), $urandom_range(40, 100), -1, 0, -1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/linebuf_ctrl.md
Name: linebuf_ctrl

Overview:
- Sequencer for a K-line BRAM line buffer in the conv datapath.
- Accepts an incoming pixel-beat handshake (each beat is P_CH*DWIDTH bits; data bypasses this block) and produces the controls: per-line write enables, write/read addresses and the rotation pointer.
- Emits a window-valid handshake toward the window/MAC stage once K-1 rows are stored.
- Runs one frame per start pulse.

Parameters:
- K, 3: window height; NUM_LINES = K physical line BRAMs.
- ADDR_W, 8: column address width; cfg_width must be <= 2^ADDR_W-1.
- ROW_W, 12: row counter width.
- LIDX_W, $clog2(K): line index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame start; latches cfg_*; ignored while busy.
- cfg_width  in  ADDR_W  pixels per row (1..2^ADDR_W-1; 0 illegal, treated as 1).
- cfg_height  in  ROW_W  rows per frame (>=1).
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&s_ready.
- wr_en  out  K  one-hot BRAM write enable (line wr_ptr).
- wr_addr  out  ADDR_W  write column.
- rd_en  out  1  read enable to all non-written lines.
- rd_addr  out  ADDR_W  read column (equals wr_addr).
- rd_line_base  out  LIDX_W  oldest stored line index, for the downstream row mux.
- win_valid  out  1  BRAM read data plus live beat form a valid column.
- m_ready  in  1  downstream accepts column.
- busy  out  1  frame in progress.
- done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset: every output is 0. State=IDLE; col, row, wr_ptr and rd_line_base are cleared.
- FSM states are IDLE, FILL, RUN and DRAIN.
  - IDLE->FILL on start: latch cfg, busy=1.
  - FILL->RUN when row reaches K-1.
  - FILL or RUN->DRAIN on acceptance of the last beat (row=H-1, col=W-1).
  - DRAIN->IDLE when win_valid==0 (or on the cycle it is consumed). done=1 on that transition; busy=0 the next cycle.
- s_ready:
  - FILL: 1.
  - RUN: (~win_valid | m_ready).
  - IDLE and DRAIN: 0.
- On each accepted beat:
  - wr_en = one-hot(wr_ptr) and wr_addr = col, combinational from registered counters, the same cycle.
  - In RUN only: rd_en=1, rd_addr=col.
- col increments; at col=W-1 it wraps to 0 and row increments.
  - wr_ptr advances modulo K using explicit compare, not a power-of-two mask: K-1 -> 0.
  - rd_line_base advances modulo K once RUN is reached. Invariant: rd_line_base = (wr_ptr+1) mod K.
- win_valid:
  - Set the cycle after an accepted RUN beat (1-cycle BRAM read latency).
  - Held while m_ready=0.
  - Cleared when m_ready=1 and no new RUN accept occurs.
  - No rd_en is issued while win_valid is held, so BRAM output stays stable.
- Edge cases:
  - H < K: RUN is never entered, no win_valid is produced, done is still pulsed.
  - W=1: col stays 0 and row advances on every beat.
  - start while busy: ignored. cfg changes mid-frame: no effect.
  - rst mid-frame: immediate return to reset values. No partial done.
- Window count per frame: exactly W*(H-K+1).

Optional Feature:
- Macro: LINEBUF_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0]: a saturating count of cycles in RUN with s_valid & ~s_ready.
  - Cleared on accepted start; holds its value after done; resets to 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package linebuf_pkg: state encoding localparams (IDLE=0, FILL=1, RUN=2, DRAIN=3), the clog2 function and the LIDX_W derivation rule.
- One sub-module, lb_ring_ptr: modulo-K pointer with inc/clear inputs. Instantiate it twice, for wr_ptr and rd_line_base.

Test Plan:
- Basic frame, K=3, W=4, H=5, s_valid=1, m_ready=1:
  - FILL accepts 8 beats: wr_en=001 x4, then 010 x4.
  - RUN accepts 12 beats, with wr_en 100 x4, then 001, then 010.
  - win_valid is high for 12 cycles, starting 1 cycle after the 9th accept.
  - rd_line_base sequence is 0,1,2.
  - done pulses once after the 20th accept.
- Backpressure: m_ready=0 for 5 cycles mid-RUN.
  - s_ready drops after one beat; win_valid stays 1.
  - rd_en=0 and rd_addr is stable.
  - Resume with no lost or duplicated column; total windows = 12.
- Ring wrap, K=3, W=2, H=7:
  - wr_ptr sequence 0,1,2,0,1,2,0.
  - rd_line_base = (wr_ptr+1)%3 on every RUN beat.
  - 10 windows.
- Short frame, H=2, K=3: 2*W beats accepted, win_valid never asserts, done pulses.
- Reset and start handling:
  - Assert rst mid-RUN: all outputs are 0 in the same cycle, state=IDLE.
  - start during busy is ignored.
  - A new start after reset runs a full correct frame.
- W=1, H=4: one beat per row, wr_ptr 0,1,2,0, 2 windows. With LINEBUF_CTRL_STALL_CNT_EN and m_ready=0 for 3 cycles: stall_cnt=3.
